sha256_wmem_sequencer: RTL and testbench
========================================

# sha256_wmem_sequencer

Sequencer for the SHA-256 message schedule in the double-SHA256 pipeline. It accepts one 512-bit padded block over a valid/ready handshake and holds it in a 16-word sliding window. It then streams W[0]..W[NUM_WORDS-1] to the round datapath, one word per accepted beat, and expands words 16 and up in place. It sits between the block source (header/padding logic or the first hash's digest repacker) and the compression rounds, and it absorbs round-side backpressure.

## Interface
- NUM_WORDS, 64, number of schedule words emitted per block; legal range 17..64
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- blk_valid  in  1  source offers a block
- blk_ready  out  1  sequencer accepts a block this cycle
- blk_data  in  512  block; W[0]=blk_data[511:480] ... W[15]=blk_data[31:0]
- abort  in  1  synchronous drop of the block in progress
- w_valid  out  1  w_data/w_idx valid
- w_ready  in  1  round datapath consumes the word
- w_data  out  32  schedule word W[w_idx]
- w_idx  out  6  round index t
- w_last  out  1  high with w_idx == NUM_WORDS-1
- busy  out  1  block in progress (state STREAM)

## Operation
- States: IDLE and STREAM.
- IDLE: blk_ready=1, w_valid=0. When blk_valid is high: load win[0..15] from blk_data, set t=0, go to STREAM.
- STREAM: w_valid=1, w_data=win[0], w_idx=t, w_last=(t==NUM_WORDS-1).
- Beat = w_valid & w_ready. On a beat with t<NUM_WORDS-1: win[i]<=win[i+1] for i=0..14; win[15]<=next; t<=t+1.
- next = s1(win[14]) + win[9] + s0(win[1]) + win[0], mod 2^32.
- s0(x) = ROTR7 ^ ROTR18 ^ SHR3. s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- The next-word computation runs on every beat, including t<16. Words loaded from the block are never overwritten before they are emitted.
- Last beat (t==NUM_WORDS-1 with w_ready high):
  - blk_ready=1 in the same cycle (combinational from w_ready).
  - If blk_valid is also high, the new block loads, t=0 and the state stays STREAM (back-to-back).
  - Otherwise the state goes to IDLE.
- No beat (w_ready low): window, t and all outputs hold. w_data must not change while w_valid=1 and w_ready=0.
- abort in STREAM: go to IDLE next cycle with no further beats. blk_ready is forced low during the abort cycle. abort in IDLE is ignored.
- abort and the last beat in the same cycle: the beat completes, blk_ready=0, next state IDLE.
- RST at any time (including mid-block): state=IDLE, t=0, window cleared to 0, partial block lost.
- Reset values: blk_ready=1, w_valid=0, w_data=0, w_idx=0, w_last=0, busy=0.

## Timing
- Block accepted in cycle N → W[0] visible (w_valid=1) in cycle N+1.
- With w_ready held high: W[t] appears in cycle N+1+t. The full block takes NUM_WORDS cycles.
- Back-to-back blocks: zero bubble cycles between W[NUM_WORDS-1] of one block and W[0] of the next.
- w_data, w_idx, w_valid, w_last and busy are register outputs.
- blk_ready is combinational from the state, w_ready, t and abort. The source must not drive blk_valid from blk_ready combinationally.
- Critical path: one 32-bit 4-operand add plus the sigma functions. No internal pipelining of the expansion is required at the target clock.

## Structure
- Package sha256_wmem_pkg holds:
  - state enum {IDLE, STREAM}
  - functions sigma0_s / sigma1_s
  - word width (32), window depth (16), index width (6)
- Sub-module sha256_wexp_step: combinational, input win[0], win[1], win[9], win[14], output next. It is reused by later compact-expander variants.
- The FSM, counter and 16x32 window stay in the top module.

## Test plan
- Block "abc" (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 → 64 beats in 64 consecutive cycles. W16=0x61626380, W17=0x000F0000. All 64 words match the software model. w_last only at w_idx=63.
- Same block with w_ready toggled pseudo-randomly → identical word sequence. w_data/w_idx stable while stalled. Exactly 64 beats.
- Two blocks with blk_valid held high → second W[0] in the cycle after first W[63]. blk_ready pulses only in the last-beat cycle.
- abort asserted at w_idx=20 → w_valid=0 the next cycle. The next block restarts at w_idx=0 with correct words.
- RST asserted at w_idx=40 for 1 cycle → all outputs at reset values immediately. The following block streams correctly from W0.
- NUM_WORDS=17 build → 17 beats, w_last at w_idx=16, W16 correct.

Source files
------------

// File: rtl/sha256_wmem_pkg.sv
// Shared types, widths and sigma helpers for the SHA-256 message-schedule sequencer.
package sha256_wmem_pkg;

  localparam int WORD_W    = 32;
  localparam int WIN_DEPTH = 16;
  localparam int IDX_W     = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  function automatic logic [WORD_W-1:0] sigma0_s(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1_s(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_wexp_step.sv
// One SHA-256 schedule expansion step: W[t+16] from the four taps of the 16-word window.
module sha256_wexp_step
  import sha256_wmem_pkg::*;
(
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w9,
  input  logic [WORD_W-1:0] w14,
  output logic [WORD_W-1:0] w_next
);

  assign w_next = sigma1_s(w14) + w9 + sigma0_s(w1) + w0;

endmodule

// File: rtl/sha256_wmem_sequencer.sv
// Holds one padded block in a 16-word sliding window and streams W[0..NUM_WORDS-1],
// expanding new words into the window tail as each word is consumed.
//
// state  | meaning
// IDLE   | waiting for a block, blk_ready high
// STREAM | presenting win[0] as W[t], shifting on each accepted beat
module sha256_wmem_sequencer
  import sha256_wmem_pkg::*;
#(
  parameter int NUM_WORDS = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [511:0]          blk_data,
  input  logic                  abort,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [WORD_W-1:0]     w_data,
  output logic [IDX_W-1:0]      w_idx,
  output logic                  w_last,
  output logic                  busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  t_q, t_d;
  logic              w_last_q, w_last_d;
  logic [WORD_W-1:0] win_q [WIN_DEPTH];
  logic [WORD_W-1:0] w_next;
  logic              at_last;
  logic              load;
  logic              shift;

  sha256_wexp_step u_step (
    .w0     (win_q[0]),
    .w1     (win_q[1]),
    .w9     (win_q[9]),
    .w14    (win_q[14]),
    .w_next (w_next)
  );

  assign at_last = (t_q == LAST_IDX);

  // Ready for a new block in IDLE, or in the same cycle as the final beat so blocks chain with no bubble.
  always_comb begin
    blk_ready = 1'b0;
    case (state_q)
      IDLE:    blk_ready = 1'b1;
      STREAM:  blk_ready = w_ready & at_last & ~abort;
      default: blk_ready = 1'b0;
    endcase
  end

  assign load = blk_valid & blk_ready;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (blk_valid) begin
          state_d = STREAM;
          t_d     = '0;
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (w_ready) begin
          if (!at_last) begin
            shift = 1'b1;
            t_d   = t_q + IDX_W'(1);
          end else if (blk_valid) begin
            t_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    w_last_d = (state_d == STREAM) && (t_d == LAST_IDX);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      t_q      <= '0;
      w_last_q <= 1'b0;
      for (int i = 0; i < WIN_DEPTH; i++) win_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      w_last_q <= w_last_d;
      if (load) begin
        for (int i = 0; i < WIN_DEPTH; i++)
          win_q[i] <= blk_data[(WIN_DEPTH-1-i)*WORD_W +: WORD_W];
      end else if (shift) begin
        for (int i = 0; i < WIN_DEPTH-1; i++) win_q[i] <= win_q[i+1];
        win_q[WIN_DEPTH-1] <= w_next;
      end
    end
  end

  assign w_valid = (state_q == STREAM);
  assign busy    = (state_q == STREAM);
  assign w_data  = win_q[0];
  assign w_idx   = t_q;
  assign w_last  = w_last_q;

endmodule

// File: tb/tb_sha256_wmem_sequencer.sv
// Self-checking bench: table of blocks streamed through a scoreboard, plus
// back-to-back, abort, reset and NUM_WORDS=17 sequences.
module tb_sha256_wmem_sequencer;

  logic         CLK = 1'b0;
  logic         RST;
  logic         blk_valid, blk_ready, abort, w_valid, w_ready, w_last, busy;
  logic [511:0] blk_data;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;

  logic         blk_valid17, blk_ready17, abort17, w_valid17, w_ready17, w_last17, busy17;
  logic [511:0] blk_data17;
  logic [31:0]  w_data17;
  logic [5:0]   w_idx17;

  always #5 CLK = ~CLK;

  sha256_wmem_sequencer #(.NUM_WORDS(64)) dut (
    .CLK(CLK), .RST(RST), .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .abort(abort), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_idx(w_idx),
    .w_last(w_last), .busy(busy));

  sha256_wmem_sequencer #(.NUM_WORDS(17)) dut17 (
    .CLK(CLK), .RST(RST), .blk_valid(blk_valid17), .blk_ready(blk_ready17), .blk_data(blk_data17),
    .abort(abort17), .w_valid(w_valid17), .w_ready(w_ready17), .w_data(w_data17), .w_idx(w_idx17),
    .w_last(w_last17), .busy(busy17));

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [511:0] blk;
    bit           rnd;
    bit           chk_w;
    logic [31:0]  w16;
    logic [31:0]  w17;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[4];
  logic [31:0] ws[64];
  logic [31:0] got_w[64];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          rand_mode = 0;
  bit          timing_mode = 0;
  bit          b2b_mode = 0;
  bit          prev_was_last = 0;
  int          last_beat_cyc = 0;
  logic [511:0] abc_blk;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] ts0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ts1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic build_sched(input logic [511:0] b);
    for (int i = 0; i < 16; i++) ws[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++) ws[i] = ts1(ws[i-2]) + ws[i-7] + ts0(ws[i-15]) + ws[i-16];
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // w_ready driver: constant high or pseudo-random backpressure.
  initial begin
    w_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      w_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pops, stall stability, blk_ready pulse, beat timing.
  initial begin
    bit          hold_prev;
    logic [31:0] hold_data;
    logic [5:0]  hold_idx;
    exp_t        e;
    hold_prev = 0;
    hold_data = '0;
    hold_idx  = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        hold_prev = 0;
      end else begin
        if (busy)
          check("blk_ready_pulse", blk_ready, w_valid & w_ready & w_last & ~abort);
        if (w_valid && hold_prev) begin
          check("stall_data", w_data, hold_data);
          check("stall_idx", w_idx, hold_idx);
        end
        if (w_valid && w_ready) begin
          if (sb.size() == 0) begin
            check("extra_beat", 1'b1, 1'b0);
          end else begin
            e = sb.pop_front();
            check("beat_idx", w_idx, e.idx);
            check("beat_data", w_data, e.data);
            check("beat_last", w_last, e.last);
            got_w[w_idx] = w_data;
          end
          if (timing_mode && (w_idx != 0 || (b2b_mode && prev_was_last)))
            check("beat_gap", cyc, last_beat_cyc + 1);
          last_beat_cyc = cyc;
          prev_was_last = w_last;
        end
        hold_prev = w_valid && !w_ready;
        hold_data = w_data;
        hold_idx  = w_idx;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send_block(input logic [511:0] b, input bit keep);
    bit acc;
    acc = 0;
    blk_data  = b;
    blk_valid = 1'b1;
    for (int n = 0; n < 400 && !acc; n++) begin
      @(negedge CLK);
      if (blk_ready) begin
        acc = 1;
        build_sched(b);
        for (int i = 0; i < 64; i++) sb.push_back('{6'(i), ws[i], (i == 63)});
      end
    end
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    blk_valid = keep;
    check("first_word_valid", w_valid, 1'b1);
    check("first_word_idx", w_idx, 6'd0);
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge CLK);
      if (sb.size() == 0 && !w_valid) done = 1;
    end
    check({"done_", name}, sb.size(), 0);
    check({"idle_", name}, w_valid, 1'b0);
    prev_was_last = 0;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idx(input logic [5:0] idx);
    bit hit;
    hit = 0;
    for (int n = 0; n < 400 && !hit; n++) begin
      @(posedge CLK);
      #1;
      if (w_valid && w_idx == idx) hit = 1;
    end
    if (!hit) check("wait_idx_timeout", w_idx, idx);
  endtask

  initial begin
    logic [511:0] rblk;
    int           n17;
    bit           end17;

    abc_blk = {32'h61626380, {14{32'h0}}, 32'h00000018};
    for (int i = 0; i < 16; i++) rblk[32*i +: 32] = $urandom;

    vt[0] = '{abc_blk, 1'b0, 1'b1, 32'h61626380, 32'h000F0000};
    vt[1] = '{abc_blk, 1'b1, 1'b1, 32'h61626380, 32'h000F0000};
    vt[2] = '{rblk,    1'b0, 1'b0, 32'h0, 32'h0};
    vt[3] = '{~rblk,   1'b1, 1'b0, 32'h0, 32'h0};

    RST = 1'b1;
    blk_valid = 1'b0; blk_data = '0; abort = 1'b0;
    blk_valid17 = 1'b0; blk_data17 = '0; abort17 = 1'b0; w_ready17 = 1'b1;
    #1;
    check("rst_blk_ready", blk_ready, 1'b1);
    check("rst_w_valid", w_valid, 1'b0);
    check("rst_w_data", w_data, 32'h0);
    check("rst_w_idx", w_idx, 6'd0);
    check("rst_w_last", w_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    for (int k = 0; k < 4; k++) begin
      rand_mode   = vt[k].rnd;
      timing_mode = !vt[k].rnd;
      send_block(vt[k].blk, 1'b0);
      wait_done($sformatf("vec%0d", k));
      if (vt[k].chk_w) begin
        check("w16", got_w[16], vt[k].w16);
        check("w17", got_w[17], vt[k].w17);
      end
    end

    // Back-to-back with blk_valid held high.
    rand_mode = 0; timing_mode = 1; b2b_mode = 1;
    send_block(rblk, 1'b1);
    send_block(abc_blk, 1'b0);
    wait_done("b2b");
    b2b_mode = 0; timing_mode = 0;

    // Abort at W[20].
    send_block(rblk, 1'b0);
    wait_idx(6'd20);
    abort = 1'b1;
    #1;
    check("abort_blk_ready", blk_ready, 1'b0);
    @(posedge CLK);
    #1;
    abort = 1'b0;
    check("abort_w_valid", w_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    sb.delete();
    send_block(abc_blk, 1'b0);
    wait_done("after_abort");

    // Reset at W[40].
    send_block(~rblk, 1'b0);
    wait_idx(6'd40);
    RST = 1'b1;
    #1;
    check("mid_rst_w_valid", w_valid, 1'b0);
    check("mid_rst_w_idx", w_idx, 6'd0);
    check("mid_rst_w_data", w_data, 32'h0);
    check("mid_rst_w_last", w_last, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_blk_ready", blk_ready, 1'b1);
    sb.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    rand_mode = 1;
    send_block(rblk, 1'b0);
    wait_done("after_rst");
    rand_mode = 0;

    // NUM_WORDS=17 instance.
    build_sched(abc_blk);
    blk_data17  = abc_blk;
    blk_valid17 = 1'b1;
    @(posedge CLK);
    #1;
    blk_valid17 = 1'b0;
    n17 = 0;
    end17 = 0;
    for (int n = 0; n < 40 && !end17; n++) begin
      @(negedge CLK);
      if (w_valid17 && w_ready17) begin
        check("n17_idx", w_idx17, 6'(n17));
        check("n17_data", w_data17, ws[n17 % 64]);
        check("n17_last", w_last17, (n17 == 16));
        n17++;
      end else if (n17 > 0) begin
        end17 = 1;
      end
    end
    check("n17_beats", n17, 17);
    check("n17_idle", w_valid17, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
